// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Brief    : Shared constants, state encoding and twiddle-index helper for
//            the radix-2 DIT FFT address sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int C_LOG2N_DEF  = 10;
    localparam int C_N_DEF      = 1 << C_LOG2N_DEF;
    localparam int C_HALF_N_DEF = C_N_DEF / 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_GAP   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Twiddle exponent for stage s: W_N^(pos * N / 2^(s+1)).
    function automatic logic [31:0] tw_shift(input logic [31:0] pos,
                                             input logic [31:0] s,
                                             input logic [31:0] log2n);
        return pos << (log2n - 32'd1 - s);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_align_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fft_align_pipe
// Brief    : DEPTH-stage register delay line with synchronous flush, used to
//            line butterfly addresses up with the twiddle ROM output.
// Revision : 1.0 - initial release
// ============================================================================
module fft_align_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] w_in;
        logic [WIDTH-1:0] r_q;

        if (i == 0) begin : g_head
            assign w_in = i_d;
        end else begin : g_tail
            assign w_in = g_stage[i-1].r_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_q <= '0;
            end else if (i_flush) begin
                r_q <= '0;
            end else begin
                r_q <= w_in;
            end
        end
    end

    assign o_q = g_stage[DEPTH-1].r_q;

endmodule
`default_nettype wire

// File: rtl/fft_twiddle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fft_twiddle_sequencer
// Brief    : Stage/butterfly sequencer for an in-place radix-2 DIT FFT; drives
//            the twiddle ROM address and ROM-aligned butterfly addresses.
// Revision : 1.0 - initial release
// ============================================================================
module fft_twiddle_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N   = C_LOG2N_DEF,
    parameter int ROM_LAT = 1,
    parameter int GAP     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    output logic [LOG2N-2:0]          tw_addr,
    output logic                      bf_valid,
    output logic [LOG2N-1:0]          bf_addr_a,
    output logic [LOG2N-1:0]          bf_addr_b,
    output logic [$clog2(LOG2N)-1:0]  bf_stage,
    output logic                      bf_last,
    output logic                      busy,
    output logic                      done
);

    localparam int C_AW = LOG2N;
    localparam int C_TW = LOG2N - 1;
    localparam int C_SW = $clog2(LOG2N);
    localparam int C_GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int C_DW = $clog2(ROM_LAT + 1);
    localparam int C_PW = 2 * C_AW + C_SW + 2;

    localparam logic [C_TW-1:0] C_J_LAST     = C_TW'((1 << (LOG2N - 1)) - 1);
    localparam logic [C_SW-1:0] C_S_LAST     = C_SW'(LOG2N - 1);
    localparam logic [C_GW-1:0] C_GAP_LOAD   = C_GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [C_DW-1:0] C_DRAIN_LOAD = C_DW'(ROM_LAT - 1);

    state_t            r_state;
    logic [C_SW-1:0]   r_s;
    logic [C_TW-1:0]   r_j;
    logic [C_GW-1:0]   r_gap_cnt;
    logic [C_DW-1:0]   r_drain_cnt;

    logic              w_run;
    logic              w_last;
    logic [C_AW-1:0]   w_j_ext;
    logic [C_AW-1:0]   w_span;
    logic [C_AW-1:0]   w_pos;
    logic [C_AW-1:0]   w_grp;
    logic [C_AW-1:0]   w_a;
    logic [C_AW-1:0]   w_b;
    logic [C_TW-1:0]   w_tw;
    logic [C_PW-1:0]   w_pipe_d;
    logic [C_PW-1:0]   w_pipe_q;

    // Butterfly j of stage s splits into a group index and a position in the group.
    assign w_run   = (r_state == ST_RUN);
    assign w_j_ext = {1'b0, r_j};
    assign w_span  = C_AW'(1) << r_s;
    assign w_pos   = w_j_ext & (w_span - 1'b1);
    assign w_grp   = w_j_ext >> r_s;
    assign w_a     = ((w_grp << r_s) << 1) | w_pos;
    assign w_b     = w_a + w_span;
    assign w_tw    = C_TW'(tw_shift(32'(w_pos), 32'(r_s), 32'(LOG2N)));
    assign w_last  = w_run && (r_s == C_S_LAST) && (r_j == C_J_LAST);

    assign tw_addr  = w_run ? w_tw : '0;
    assign w_pipe_d = w_run ? {w_a, w_b, r_s, 1'b1, w_last} : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_s         <= '0;
            r_j         <= '0;
            r_gap_cnt   <= '0;
            r_drain_cnt <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                r_state     <= ST_IDLE;
                r_s         <= '0;
                r_j         <= '0;
                r_gap_cnt   <= '0;
                r_drain_cnt <= '0;
                busy        <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_state <= ST_RUN;
                            r_s     <= '0;
                            r_j     <= '0;
                            busy    <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (r_j == C_J_LAST) begin
                            r_j <= '0;
                            if (r_s == C_S_LAST) begin
                                r_state     <= ST_DRAIN;
                                r_drain_cnt <= C_DRAIN_LOAD;
                            end else if (GAP > 0) begin
                                r_state   <= ST_GAP;
                                r_gap_cnt <= C_GAP_LOAD;
                            end else begin
                                r_s <= r_s + 1'b1;
                            end
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (r_gap_cnt == '0) begin
                            r_state <= ST_RUN;
                            r_s     <= r_s + 1'b1;
                        end else begin
                            r_gap_cnt <= r_gap_cnt - 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        if (r_drain_cnt == '0) begin
                            r_state <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_drain_cnt <= r_drain_cnt - 1'b1;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    fft_align_pipe #(
        .WIDTH (C_PW),
        .DEPTH (ROM_LAT)
    ) u_align (
        .clk     (clk),
        .rst     (rst),
        .i_flush (abort),
        .i_d     (w_pipe_d),
        .o_q     (w_pipe_q)
    );

    assign {bf_addr_a, bf_addr_b, bf_stage, bf_valid, bf_last} = w_pipe_q;

endmodule
`default_nettype wire

// File: doc/fft_twiddle_sequencer.md
Name: fft_twiddle_sequencer

Overview:
- Sequences one in-place radix-2 DIT FFT of N = 2^LOG2N points, stage by stage and butterfly by butterfly.
- Drives the address of the shared twiddle ROM pair (real and imaginary, 1-cycle registered read, depth N/2).
- Emits data-memory butterfly addresses delayed by ROM_LAT, so they arrive in the same cycle as the matching twiddle ROM q.
- Inserts GAP idle cycles between stages so the downstream butterfly pipeline can drain before the next stage reads its results.

Parameters:
- LOG2N, 10, log2 of FFT size; twiddle address width is LOG2N-1 (9 by default).
- ROM_LAT, 1, twiddle ROM read latency in cycles (at least 1).
- GAP, 4, idle cycles inserted between consecutive stages (0 allowed).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a transform; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- tw_addr  out  LOG2N-1  twiddle ROM address; connects to both the real and imaginary ROMs.
- bf_valid  out  1  butterfly outputs are valid; aligned with ROM q.
- bf_addr_a  out  LOG2N  upper-leg data address.
- bf_addr_b  out  LOG2N  lower-leg data address.
- bf_stage  out  clog2(LOG2N)  stage index of the current butterfly.
- bf_last  out  1  marks the final butterfly of the final stage.
- busy  out  1  high from the first RUN cycle until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
Reset:
- All outputs are 0; state is IDLE; stage s = 0; butterfly index j = 0.
- The ROM_LAT delay pipe is cleared.

States: IDLE, RUN, GAP, DRAIN, DONE.
- IDLE:
  - start=1 -> RUN with s=0, j=0.
  - busy rises in the same cycle as the first RUN cycle.
- RUN:
  - One butterfly per cycle; j increments each cycle.
  - span = 2^s; pos = j & (span-1); grp = j >> s.
  - tw_addr = pos << (LOG2N-1-s), truncated to LOG2N-1 bits.
  - Computed addresses: a = grp*2*span + pos; b = a + span.
  - When j = N/2-1:
    - s = LOG2N-1 -> DRAIN.
    - Otherwise GAP>0 -> GAP.
    - Otherwise GAP=0 -> stay in RUN with s+1, j=0; no bubble.
- GAP:
  - Down-counter loaded with GAP.
  - Expires -> RUN with s+1, j=0.
- DRAIN:
  - Waits ROM_LAT cycles so the last butterfly reaches the outputs -> DONE.
- DONE:
  - done=1 and busy=0 for one cycle -> IDLE.
- tw_addr holds 0 outside RUN.

Output alignment:
- {a, b, s, valid, last} pass through a ROM_LAT-deep register pipe to become bf_*.
- A butterfly issued in cycle t has bf_valid in cycle t+ROM_LAT, together with q(tw_addr issued in cycle t).

Total run length:
- Counted from the start-sampling edge, done is high in cycle LOG2N*N/2 + (LOG2N-1)*GAP + ROM_LAT + 1.

Boundary cases:
- start while busy: ignored.
- start and abort in the same IDLE cycle: abort wins; stay in IDLE.
- abort: next cycle is IDLE; the delay pipe is flushed (bf_valid=0); done is not pulsed.
- rst mid-transform: immediate return to reset values.
- Address arithmetic is unsigned LOG2N bits and never overflows (b ≤ N-1).
- No backpressure; the consumer must accept one butterfly per cycle.

Decomposition:
- Shared package fft_pkg:
  - LOG2N default; N and N/2 constants.
  - State enum encoding.
  - Function for the twiddle shift (pos << (LOG2N-1-s)).
- One natural sub-module: fft_align_pipe, a parameterised-width, ROM_LAT-deep register delay line with synchronous flush on abort.

Test Plan:
- LOG2N=3, GAP=2, ROM_LAT=1, start pulse at cycle 0:
  - Stage 0: (a,b,tw) = (0,1,0) (2,3,0) (4,5,0) (6,7,0).
  - Stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2).
  - Stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3).
  - bf_valid high in cycles 2-5, 8-11, 14-17; bf_last in cycle 17; done in cycle 18.
- Same configuration with GAP=0: 12 consecutive bf_valid cycles (2-13) with no bubble; done in cycle 14.
- abort asserted in cycle 9: bf_valid=0 from cycle 10; busy=0; done never pulses. A new start then runs a full correct sequence.
- start re-pulsed during cycles 3 and 10 of a run: no effect on the sequence; exactly one done.
- rst asserted asynchronously mid-stage-1: all outputs read 0 immediately, before the next clock edge.
- Default LOG2N=10, ROM_LAT=1, GAP=4, cross-checked against a reference model:
  - Every stage gives 512 butterflies.
  - Final stage: tw_addr = j for j = 0..511.
  - done in cycle 5120 + 36 + 2 = 5158.
